// File: rtl/pipe_stage.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry skid, flush to NOP.
// Latency 1 cycle; SKID=1 registers in_ready, SKID=0 passes out_ready through to in_ready.
module pipe_stage #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] NOP   = '0,
  parameter bit               SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_q, m_nxt;
  logic [WIDTH-1:0] s_q, s_nxt;
  logic             push, pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? m_q : NOP;
  assign count     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      m_q   <= NOP;
      s_q   <= NOP;
    end else begin
      state <= state_nxt;
      m_q   <= m_nxt;
      s_q   <= s_nxt;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic rdy_q;

      assign in_ready = rdy_q;

      always_comb begin
        state_nxt = state;
        m_nxt     = m_q;
        s_nxt     = s_q;
        case (state)
          EMPTY: begin
            if (push) begin
              m_nxt     = in_data;
              state_nxt = ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              m_nxt = in_data;
            end else if (push) begin
              s_nxt     = in_data;
              state_nxt = FULL;
            end else if (pop) begin
              state_nxt = EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              m_nxt     = s_q;
              state_nxt = ONE;
            end
          end
          default: state_nxt = EMPTY;
        endcase
        // Anything accepted while flushing is dropped; the upstream handshake still completes.
        if (flush) state_nxt = EMPTY;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b1;
        else     rdy_q <= (state_nxt != FULL);
      end
    end else begin : g_single
      assign in_ready = (state == EMPTY) | out_ready;

      always_comb begin
        state_nxt = state;
        m_nxt     = m_q;
        s_nxt     = s_q;
        if (push) begin
          m_nxt     = in_data;
          state_nxt = ONE;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
        if (flush) state_nxt = EMPTY;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: SKID=1 instance with a scoreboard, plus a SKID=0 instance.
module tb_pipe_stage;

  localparam int          W    = 64;
  localparam logic [63:0] NOPV = 64'h13;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  logic         f0, v0, r0;
  logic [W-1:0] d0;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   count0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(W), .NOP(NOPV), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_stage #(.WIDTH(W), .NOP(NOPV), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(f0),
    .in_valid(v0), .in_ready(in_ready0), .in_data(d0),
    .out_valid(out_valid0), .out_ready(r0), .out_data(out_data0),
    .count(count0)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard runs on the falling edge, when inputs and outputs are settled for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_pop", out_data, NOPV ^ out_data ^ 64'h1);
        else                  check("sb_data", out_data, sb_q.pop_front());
      end
      if (flush)                     sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b0;
    f0 = 1'b0; v0 = 1'b0; d0 = '0; r0 = 1'b0;

    // Reset holds the stage empty even with in_valid high
    tick(); tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, NOPV);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();
    check("first_push_count", 64'(count), 64'd1);
    check("first_push_data", out_data, 64'h77);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_nop", out_data, NOPV);

    // Streaming at full rate
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 64'(i);
      tick();
      check("stream_data", out_data, 64'(i));
      check("stream_count", 64'(count), 64'd1);
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_empty", 64'(count), 64'd0);

    // Backpressure fills the skid, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    check("bp_count_full", 64'(count), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_head", out_data, 64'hA);
    in_data = 64'hC;
    tick();
    check("bp_hold_count", 64'(count), 64'd2);
    check("bp_hold_head", out_data, 64'hA);
    out_ready = 1'b1;
    tick();
    check("bp_drain_b", out_data, 64'hB);
    check("bp_drain_count", 64'(count), 64'd1);
    check("bp_drain_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_drain_c", out_data, 64'hC);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(count), 64'd0);

    // Simultaneous push and pop in ONE
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h5;
    tick();
    check("pp_head5", out_data, 64'h5);
    in_data = 64'h6; out_ready = 1'b1;
    tick();
    check("pp_head6", out_data, 64'h6);
    check("pp_count", 64'(count), 64'd1);
    in_valid = 1'b0;
    tick();

    // Flush from FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE1;
    tick();
    in_data = 64'hE2;
    tick();
    check("fl_full", 64'(count), 64'd2);
    flush = 1'b1; in_data = 64'hD;
    tick();
    check("fl_count", 64'(count), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_data", out_data, NOPV);
    check("fl_in_ready", 64'(in_ready), 64'd1);

    // Flush in ONE drops a payload accepted in the same cycle
    flush = 1'b0; in_data = 64'h8;
    tick();
    flush = 1'b1; in_data = 64'hD;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_count", 64'(count), 64'd0);
    tick();
    check("fl1_still_empty", 64'(count), 64'd0);
    check("fl1_nop", out_data, NOPV);

    // Asynchronous reset mid-transfer
    in_valid = 1'b1; in_data = 64'h9;
    tick();
    check("ar_loaded", 64'(count), 64'd1);
    in_data = 64'h99;
    #2 rst = 1'b1;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_out_data", out_data, NOPV);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("ar_no_capture", 64'(count), 64'd0);
    rst = 1'b0;
    tick();
    check("ar_first_push", out_data, 64'h99);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    // SKID=0: combinational out_ready -> in_ready
    v0 = 1'b1; d0 = 64'h21; r0 = 1'b0;
    tick();
    check("s0_count", 64'(count0), 64'd1);
    check("s0_head", out_data0, 64'h21);
    check("s0_in_ready_low", 64'(in_ready0), 64'd0);
    r0 = 1'b1; d0 = 64'h22;
    #1;
    check("s0_in_ready_comb", 64'(in_ready0), 64'd1);
    tick();
    check("s0_new_head", out_data0, 64'h22);
    check("s0_count1", 64'(count0), 64'd1);
    v0 = 1'b0;
    tick();
    check("s0_empty", 64'(count0), 64'd0);
    check("s0_nop", out_data0, NOPV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
